shift_right_iter: RTL and testbench
===================================

Name: shift_right_iter

Overview:
Multi-cycle shift-right unit for the MIPS-32 datapath. It executes SRL/SRLV and SRA/SRAV one bit position per clock, as the complement of the fixed combinational left shift used for branch offsets. A start/busy/done handshake lets the ALU stage or control FSM stall while it runs. It trades latency (up to 32 cycles) for the area of a full barrel shifter.

Parameters:
- DATA_W, 32, operand/result width in bits
- SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W == DATA_W

Ports:
- i_clk  input  1  single system clock; all state updates on its rising edge
- i_rst_n  input  1  reset, asynchronous assert, active-low
- i_start  input  1  request; sampled only in IDLE
- i_data  input  DATA_W  operand (rt value)
- i_shamt  input  SHAMT_W  shift amount (shamt field or rs[4:0])
- i_arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill)
- i_left  input  1  present only with SHIFT_LEFT_EN; 1 = shift left
- o_busy  output  1  high in SHIFT and DONE
- o_done  output  1  one-cycle completion pulse
- o_result  output  DATA_W  shifted value; valid when o_done is high, held afterwards

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values: state=IDLE, o_result=0, count=0, o_busy=0, o_done=0, latched mode bits=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, i_start=1 at edge T0:
  - latch i_data into o_result, i_shamt into count, and i_arith (and i_left) into mode regs.
  - next state is DONE if i_shamt==0, else SHIFT.
- IDLE, i_start=0: hold all registers.
- SHIFT, each edge:
  - logical: o_result <= {1'b0, o_result[DATA_W-1:1]}
  - arithmetic: o_result <= {o_result[DATA_W-1], o_result[DATA_W-1:1]}
  - count decrements by 1; when count==1 at the edge, next state is DONE.
- DONE: o_done=1 for exactly one cycle; next state is IDLE.
- Latency: o_done is high in the cycle following edge T0+shamt (shamt=0 gives done in the cycle right after the start edge). Total occupancy is shamt+1 cycles.
- o_busy, o_done: decoded from registered state; no combinational path from any input.
- i_start while in SHIFT or DONE: ignored, with no queuing. The earliest new start is the cycle after o_done.
- Inputs change after T0: no effect; operands are latched at T0.
- o_result between operations: holds the last result until the next accepted start.
- Arithmetic fill: uses the current MSB, which equals the original sign bit for every shift amount.
- Reset mid-operation: immediate return to IDLE with the reset values; the partial result is discarded and no o_done is produced.
- Shift amount range: shamt=DATA_W-1 is the maximum; there is no overflow case, since count is SHAMT_W bits wide.

Optional Feature:
- Macro: SHIFT_LEFT_EN
- With the macro defined:
  - port i_left exists and is latched at start.
  - when the latched left bit is 1, each SHIFT edge does o_result <= {o_result[DATA_W-2:0], 1'b0}, and i_arith is ignored.
  - timing and handshake are identical to the right shift.
  - this covers SLL/SLLV.
- Without the macro: no i_left port, and only right shifts are implemented.

Test Plan:
- Logical right shift: i_data=0xF000_0000, i_shamt=4, i_arith=0, start at T0 -> o_done high only in the cycle after T0+4; o_result=0x0F00_0000; o_busy high from T0+1 to T0+5 inclusive.
- Arithmetic, maximum shift: i_data=0x8000_0000, i_shamt=31, i_arith=1 -> o_result=0xFFFF_FFFF after 32 cycles. Repeat with i_data=0x7FFF_FFFF -> 0x0000_0000.
- Zero shift amount: i_data=0x1234_5678, i_shamt=0 -> o_done in the cycle after start, o_result=0x1234_5678.
- Start while busy: start i_shamt=8 on 0xFFFF_0000 logical, then pulse i_start with i_data=0 at T0+3 -> result 0x00FF_FF00, a single o_done pulse. A new start the cycle after done is accepted.
- Reset mid-operation: drop i_rst_n at T0+2 of a 10-bit shift -> o_busy, o_done and o_result are 0 immediately, without waiting for a clock edge. After release, an idle bench shows no o_done.
- Left shift (SHIFT_LEFT_EN defined): i_data=0x0000_0001, i_shamt=2, i_left=1 -> o_result=0x0000_0004, o_done after 2+1 cycles.

Source files
------------

// File: rtl/shift_right_iter.sv
// Iterative one-bit-per-cycle shifter for SRL/SRLV/SRA/SRAV with start/busy/done handshake.
// Define SHIFT_LEFT_EN to add the i_left port and SLL/SLLV support.
module shift_right_iter #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [DATA_W-1:0]  i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic               i_arith,
`ifdef SHIFT_LEFT_EN
    input  logic               i_left,
`endif
    output logic               o_busy,
    output logic               o_done,
    output logic [DATA_W-1:0]  o_result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [SHAMT_W-1:0]  count_q, count_d;
    logic                arith_q, arith_d;
`ifdef SHIFT_LEFT_EN
    logic                left_q, left_d;
`endif
    logic [DATA_W-1:0]   shifted;

    // Sign fill reuses the live MSB; it never changes during a right shift.
    always_comb begin
        shifted = {arith_q & result_q[DATA_W-1], result_q[DATA_W-1:1]};
`ifdef SHIFT_LEFT_EN
        if (left_q) begin
            shifted = {result_q[DATA_W-2:0], 1'b0};
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        count_d  = count_q;
        arith_d  = arith_q;
`ifdef SHIFT_LEFT_EN
        left_d   = left_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    result_d = i_data;
                    count_d  = i_shamt;
                    arith_d  = i_arith;
`ifdef SHIFT_LEFT_EN
                    left_d   = i_left;
`endif
                    state_d  = (i_shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                result_d = shifted;
                count_d  = count_q - CNT_ONE;
                if (count_q == CNT_ONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            count_q  <= '0;
            arith_q  <= 1'b0;
`ifdef SHIFT_LEFT_EN
            left_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            count_q  <= count_d;
            arith_q  <= arith_d;
`ifdef SHIFT_LEFT_EN
            left_q   <= left_d;
`endif
        end
    end

    assign o_busy   = (state_q != IDLE);
    assign o_done   = (state_q == DONE);
    assign o_result = result_q;

endmodule

// File: tb/tb_shift_right_iter.sv
// Scoreboard bench for shift_right_iter: expected result and latency queued at start, checked at o_done.
module tb_shift_right_iter;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_start;
    logic [31:0] i_data;
    logic [4:0]  i_shamt;
    logic        i_arith;
`ifdef SHIFT_LEFT_EN
    logic        i_left;
`endif
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    shift_right_iter #(.DATA_W(32), .SHAMT_W(5)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (i_start),
        .i_data   (i_data),
        .i_shamt  (i_shamt),
        .i_arith  (i_arith),
`ifdef SHIFT_LEFT_EN
        .i_left   (i_left),
`endif
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] model(input logic [31:0] d, input int s,
                                          input logic ar, input logic lf);
        if (lf)      return d << s;
        else if (ar) return 32'($signed(d) >>> s);
        else         return d >> s;
    endfunction

    // Drives one start pulse; returns just after the accepting edge T0, with operands scrambled.
    task automatic drive_start(input logic [31:0] d, input logic [4:0] s,
                               input logic ar, input logic lf);
        exp_t e;
        @(negedge i_clk);
        i_start = 1'b1;
        i_data  = d;
        i_shamt = s;
        i_arith = ar;
`ifdef SHIFT_LEFT_EN
        i_left  = lf;
`endif
        e.res = model(d, int'(s), ar, lf);
        e.lat = int'(s) + 1;
        exp_q.push_back(e);
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_data  = ~d;
        i_shamt = ~s;
        i_arith = ~ar;
    endtask

    // Counts negedges after T0 until o_done; lat = -1 when the budget runs out.
    task automatic wait_done(input int budget, output int lat, output logic [31:0] res);
        lat = -1;
        res = '0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge i_clk);
            if (o_done) begin
                lat = k;
                res = o_result;
                break;
            end
        end
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_data  = '0;
        i_shamt = '0;
        i_arith = 1'b0;
`ifdef SHIFT_LEFT_EN
        i_left  = 1'b0;
`endif
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_busy, o_done, o_result} !== 34'd0)
            $display("FAIL reset_state busy=%b done=%b result=%h expected 0/0/0", o_busy, o_done, o_result);
        else passed++;
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        checks++;
        if ({o_busy, o_done} !== 2'b00)
            $display("FAIL idle_after_reset busy=%b done=%b expected 0/0", o_busy, o_done);
        else passed++;
    endtask

    task automatic test_logical;
        exp_t e;
        int   lat = -1;
        int   bad_busy = 0;
        logic [31:0] res = '0;
        drive_start(32'hF000_0000, 5'd4, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge i_clk);
            if (o_busy !== (k <= 5)) bad_busy++;
            if (o_done && lat < 0) begin
                lat = k;
                res = o_result;
            end else if (o_done) begin
                bad_busy++;
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (bad_busy != 0) $display("FAIL logical_busy_window errors=%0d expected 0", bad_busy);
        else passed++;
        checks++;
        if (lat != e.lat) $display("FAIL logical_latency got %0d expected %0d", lat, e.lat);
        else passed++;
        checks++;
        if (res !== e.res) $display("FAIL logical_result got %h expected %h", res, e.res);
        else passed++;
        @(negedge i_clk);
        checks++;
        if (o_result !== e.res) $display("FAIL logical_result_hold got %h expected %h", o_result, e.res);
        else passed++;
    endtask

    task automatic test_arith_max;
        logic [31:0] d [2] = '{32'h8000_0000, 32'h7FFF_FFFF};
        exp_t e;
        int lat;
        logic [31:0] res;
        for (int i = 0; i < 2; i++) begin
            drive_start(d[i], 5'd31, 1'b1, 1'b0);
            wait_done(40, lat, res);
            e = exp_q.pop_front();
            checks++;
            if (lat != e.lat) $display("FAIL arith_max_latency[%0d] got %0d expected %0d", i, lat, e.lat);
            else passed++;
            checks++;
            if (res !== e.res) $display("FAIL arith_max_result[%0d] got %h expected %h", i, res, e.res);
            else passed++;
        end
    endtask

    task automatic test_zero_shift;
        exp_t e;
        int lat;
        logic [31:0] res;
        drive_start(32'h1234_5678, 5'd0, 1'b1, 1'b0);
        wait_done(5, lat, res);
        e = exp_q.pop_front();
        checks++;
        if (lat != 1) $display("FAIL zero_shift_latency got %0d expected 1", lat);
        else passed++;
        checks++;
        if (res !== e.res) $display("FAIL zero_shift_result got %h expected %h", res, e.res);
        else passed++;
    endtask

    task automatic test_start_while_busy;
        exp_t e;
        int lat = -1;
        int pulses = 0;
        logic [31:0] res = '0;
        drive_start(32'hFFFF_0000, 5'd8, 1'b0, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            @(negedge i_clk);
            i_start = (k == 3);
            i_data  = '0;
            if (o_done) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    res = o_result;
                end
            end
        end
        i_start = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (pulses != 1) $display("FAIL busy_start_pulses got %0d expected 1", pulses);
        else passed++;
        checks++;
        if (lat != e.lat) $display("FAIL busy_start_latency got %0d expected %0d", lat, e.lat);
        else passed++;
        checks++;
        if (res !== e.res) $display("FAIL busy_start_result got %h expected %h", res, e.res);
        else passed++;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int lat;
        logic [31:0] res;
        drive_start(32'h8765_4321, 5'd3, 1'b1, 1'b0);
        wait_done(10, lat, res);
        e = exp_q.pop_front();
        checks++;
        if (res !== e.res || lat != e.lat)
            $display("FAIL b2b_first got %h/%0d expected %h/%0d", res, lat, e.res, e.lat);
        else passed++;
        // Start held high in the cycle right after o_done must be accepted.
        drive_start(32'hC000_0001, 5'd1, 1'b0, 1'b0);
        wait_done(6, lat, res);
        e = exp_q.pop_front();
        checks++;
        if (res !== e.res || lat != e.lat)
            $display("FAIL b2b_second got %h/%0d expected %h/%0d", res, lat, e.res, e.lat);
        else passed++;
    endtask

    task automatic test_random;
        exp_t e;
        int lat;
        logic [31:0] res;
        for (int i = 0; i < 6; i++) begin
            drive_start($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0);
            wait_done(40, lat, res);
            e = exp_q.pop_front();
            checks++;
            if (res !== e.res || lat != e.lat)
                $display("FAIL random[%0d] got %h/%0d expected %h/%0d", i, res, lat, e.res, e.lat);
            else passed++;
        end
    endtask

    task automatic test_mid_reset;
        int pulses = 0;
        drive_start(32'hABCD_1234, 5'd10, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        repeat (2) @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_done, o_result} !== 34'd0)
            $display("FAIL mid_reset_async busy=%b done=%b result=%h expected 0/0/0", o_busy, o_done, o_result);
        else passed++;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge i_clk);
            if (o_done || o_busy) pulses++;
        end
        checks++;
        if (pulses != 0) $display("FAIL mid_reset_quiet activity=%0d expected 0", pulses);
        else passed++;
    endtask

`ifdef SHIFT_LEFT_EN
    task automatic test_left;
        exp_t e;
        int lat;
        logic [31:0] res;
        drive_start(32'h0000_0001, 5'd2, 1'b1, 1'b1);
        wait_done(8, lat, res);
        e = exp_q.pop_front();
        checks++;
        if (res !== 32'h0000_0004 || lat != 3)
            $display("FAIL left_shift got %h/%0d expected %h/%0d", res, lat, 32'h4, 3);
        else passed++;
        @(negedge i_clk);
        i_left = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_logical();
        test_arith_max();
        test_zero_shift();
        test_start_while_busy();
        test_back_to_back();
        test_random();
`ifdef SHIFT_LEFT_EN
        test_left();
`endif
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
